// File: rtl/t07_button_event_generator.sv
// t07_button_event_generator: debounced, priority-encoded push-button events with auto-repeat
//   clk       in   1  system clock, rising edge
//   nrst      in   1  asynchronous active-low reset
//   btn_raw   in   6  raw active-high button lines, async to clk (bit0=SELECT .. bit5=BACK)
//   en        in   1  enable; low forces IDLE and suppresses events
//   key_code  out  6  one-hot code of the current event, zero when key_valid=0
//   key_valid out  1  one-cycle press or repeat strobe
//   key_rpt   out  1  qualifies key_valid as a repeat event
//   key_held  out  1  high while a confirmed press is held (HELD or REPEAT)
module t07_button_event_generator #(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_RATE     = 100000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [5:0] btn_raw,
  input  logic       en,
  output logic [5:0] key_code,
  output logic       key_valid,
  output logic       key_rpt,
  output logic       key_held
);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);
  typedef enum logic [2:0] {IDLE, DEBOUNCE, HELD, REPEAT, RELEASE} state_t;
  state_t           state, state_nx;
  logic [5:0]       sync1, s, code, cand, cand_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             fire, rpt;
  logic [5:0]       key_code_nx;
  logic             key_valid_nx, key_rpt_nx, key_held_nx;
  // two-FF synchronizer per button line
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= btn_raw;
      s     <= sync1;
    end
  // isolate the lowest set bit so SELECT has the highest priority
  assign code = s & (~s + 6'd1);
  // state register, also holding the registered outputs
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_rpt   <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      cand      <= cand_nx;
      key_code  <= key_code_nx;
      key_valid <= key_valid_nx;
      key_rpt   <= key_rpt_nx;
      key_held  <= key_held_nx;
    end
  // next-state logic; fire/rpt mark the cycle whose edge registers a strobe
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cand_nx  = cand;
    fire     = 1'b0;
    rpt      = 1'b0;
    case (state)
      IDLE:
        if (s != 6'd0) begin
          cand_nx  = code;
          cnt_nx   = '0;
          state_nx = DEBOUNCE;
        end
      DEBOUNCE:
        if (code != cand) state_nx = IDLE;
        else if (cnt == DB_LAST) begin
          fire     = 1'b1;
          cnt_nx   = '0;
          state_nx = HELD;
        end else cnt_nx = cnt + 1'b1;
      HELD:
        if (code != cand) begin
          cnt_nx   = '0;
          state_nx = RELEASE;
        end else if (cnt == RD_LAST) begin
          fire     = 1'b1;
          rpt      = 1'b1;
          cnt_nx   = '0;
          state_nx = REPEAT;
        end else cnt_nx = cnt + 1'b1;
      REPEAT:
        if (code != cand) begin
          cnt_nx   = '0;
          state_nx = RELEASE;
        end else if (cnt == RR_LAST) begin
          fire   = 1'b1;
          rpt    = 1'b1;
          cnt_nx = '0;
        end else cnt_nx = cnt + 1'b1;
      RELEASE:
        // any activity restarts the quiet window; a glitch while held lands here too
        if (s != 6'd0) cnt_nx = '0;
        else if (cnt == DB_LAST) state_nx = IDLE;
        else cnt_nx = cnt + 1'b1;
      default: state_nx = IDLE;
    endcase
    if (!en) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      cand_nx  = '0;
      fire     = 1'b0;
      rpt      = 1'b0;
    end
  end
  // output logic, registered by the state register
  always_comb begin
    key_valid_nx = fire;
    key_rpt_nx   = rpt;
    key_code_nx  = fire ? cand : 6'd0;
    key_held_nx  = (state_nx == HELD) || (state_nx == REPEAT);
  end
endmodule

// File: tb/tb_t07_button_event_generator.sv
// tb_t07_button_event_generator: directed checks of press, repeat, debounce, priority, reset and enable
module tb_t07_button_event_generator;
  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [5:0] btn_raw = '0;
  logic       en = 1'b1;
  logic [5:0] key_code;
  logic       key_valid, key_rpt, key_held;
  logic [8:0] got, exp_v;
  int         total = 0;
  int         bad = 0;
  t07_button_event_generator #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(8),
    .REPEAT_RATE(3),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .btn_raw(btn_raw),
    .en(en),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_rpt(key_rpt),
    .key_held(key_held)
  );
  always #5 clk = ~clk;
  assign got = {key_valid, key_rpt, key_held, key_code};
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    nrst = 1'b0;
    en = 1'b1;
    btn_raw = '0;
    repeat (3) cyc();
    total++;
    if (got !== 9'd0) begin
      bad++;
      $display("FAIL reset_held: got %b want %b", got, 9'd0);
    end
    nrst = 1'b1;
    repeat (3) cyc();
    total++;
    if (got !== 9'd0) begin
      bad++;
      $display("FAIL reset_release: got %b want %b", got, 9'd0);
    end
  endtask
  task automatic test_press_repeat();
    cyc();
    btn_raw = 6'b000010;
    for (int k = 1; k <= 22; k++) begin
      logic v, r;
      cyc();
      v = (k == 7) || (k == 15) || (k == 18) || (k == 21);
      r = v && (k != 7);
      exp_v = {v, r, k >= 7, v ? 6'b000010 : 6'b000000};
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL press_repeat edge %0d: got %b want %b", k, got, exp_v);
      end
    end
    btn_raw = '0;
    repeat (12) cyc();
    total++;
    if (got !== 9'd0) begin
      bad++;
      $display("FAIL press_repeat_release: got %b want %b", got, 9'd0);
    end
  endtask
  task automatic test_bounce();
    cyc();
    btn_raw = 6'b000100;
    for (int k = 1; k <= 14; k++) begin
      cyc();
      total++;
      if (got !== 9'd0) begin
        bad++;
        $display("FAIL bounce edge %0d: got %b want %b", k, got, 9'd0);
      end
      if (k == 2) btn_raw = '0;
    end
  endtask
  task automatic test_priority();
    logic [5:0] pats [2];
    logic [5:0] codes [2];
    pats[0] = 6'b100001;
    codes[0] = 6'b000001;
    pats[1] = 6'b101000;
    codes[1] = 6'b001000;
    for (int p = 0; p < 2; p++) begin
      cyc();
      btn_raw = pats[p];
      for (int k = 1; k <= 9; k++) begin
        cyc();
        exp_v = {k == 7, 1'b0, k >= 7, (k == 7) ? codes[p] : 6'b000000};
        total++;
        if (got !== exp_v) begin
          bad++;
          $display("FAIL priority pat %b edge %0d: got %b want %b", pats[p], k, got, exp_v);
        end
      end
      btn_raw = '0;
      repeat (12) cyc();
    end
  endtask
  task automatic test_release_bounce();
    cyc();
    btn_raw = 6'b000001;
    for (int k = 1; k <= 30; k++) begin
      logic v, h;
      cyc();
      v = (k == 7) || (k == 28);
      h = (k >= 7 && k < 10) || (k >= 28);
      exp_v = {v, 1'b0, h, v ? 6'b000001 : 6'b000000};
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL release_bounce edge %0d: got %b want %b", k, got, exp_v);
      end
      if (k >= 7 && k <= 16) btn_raw = ((k - 7) % 2 == 1) ? 6'b000001 : 6'b000000;
      else if (k >= 17 && k <= 20) btn_raw = '0;
      else if (k == 21) btn_raw = 6'b000001;
    end
    btn_raw = '0;
    repeat (12) cyc();
  endtask
  task automatic test_reset_in_repeat();
    cyc();
    btn_raw = 6'b000010;
    repeat (16) cyc();
    total++;
    if (key_held !== 1'b1) begin
      bad++;
      $display("FAIL repeat_before_reset: key_held got %b want 1", key_held);
    end
    #2 nrst = 1'b0;
    #1;
    total++;
    if (got !== 9'd0) begin
      bad++;
      $display("FAIL async_reset: got %b want %b", got, 9'd0);
    end
    btn_raw = '0;
    repeat (3) cyc();
    nrst = 1'b1;
    repeat (3) cyc();
    total++;
    if (got !== 9'd0) begin
      bad++;
      $display("FAIL after_reset: got %b want %b", got, 9'd0);
    end
  endtask
  task automatic test_enable();
    cyc();
    btn_raw = 6'b000001;
    for (int k = 1; k <= 17; k++) begin
      cyc();
      exp_v = {k == 15, 1'b0, k == 15 || k == 16, (k == 15) ? 6'b000001 : 6'b000000};
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL enable edge %0d: got %b want %b", k, got, exp_v);
      end
      if (k == 4) en = 1'b0;
      if (k == 10) en = 1'b1;
      if (k == 16) en = 1'b0;
    end
    en = 1'b1;
    btn_raw = '0;
    repeat (12) cyc();
    total++;
    if (got !== 9'd0) begin
      bad++;
      $display("FAIL enable_release: got %b want %b", got, 9'd0);
    end
  endtask
  initial begin
    test_reset();
    test_press_repeat();
    test_bounce();
    test_priority();
    test_release_bounce();
    test_reset_in_repeat();
    test_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
